// File: rtl/usb_status_pkg.sv
// Shared types and defaults for the status-screen UART scheduler.
package usb_status_pkg;

  localparam int FRAME_LEN_DEFAULT      = 330;
  localparam int REFRESH_CYCLES_DEFAULT = 4800000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ANN_REQ = 2'd1,
    ST_ANN_CAP = 2'd2,
    ST_SEND    = 2'd3
  } sched_state_t;

  typedef enum logic {
    SRC_ANN = 1'b0,
    SRC_CON = 1'b1
  } tx_src_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/refresh_ticker.sv
// Free-running refresh timer: one-cycle tick every REFRESH_CYCLES clocks.
module refresh_ticker
  import usb_status_pkg::*;
#(
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEFAULT
) (
  input  logic clk48,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = cnt_width(REFRESH_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/status_tx_scheduler.sv
// Arbitrates annunciator status frames and console bytes onto one UART byte stream.
//   state   | meaning
//   IDLE    | nothing in flight; pick frame or console byte
//   ANN_REQ | pulse ann_inc to fetch the next frame byte
//   ANN_CAP | capture ann_q into the transmit holding register
//   SEND    | offer tx_data until the UART takes it (src = ANN or CON)
module status_tx_scheduler
  import usb_status_pkg::*;
#(
  parameter int FRAME_LEN      = FRAME_LEN_DEFAULT,
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEFAULT
) (
  input  logic       clk48,
  input  logic       rst,
  output logic       ann_inc,
  input  logic [7:0] ann_q,
  input  logic       con_valid,
  input  logic [7:0] con_data,
  output logic       con_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       frame_active,
  output logic       frame_overrun
);

  localparam int            BW    = cnt_width(FRAME_LEN);
  localparam logic [BW-1:0] BLAST = BW'(FRAME_LEN - 1);

  sched_state_t  state, state_nxt;
  tx_src_t       src, src_nxt;
  logic [7:0]    tx_data_nxt;
  logic [BW-1:0] byte_cnt, byte_cnt_nxt;
  logic          frame_active_nxt;
  logic          frame_pend, frame_pend_nxt;
  logic          frame_overrun_nxt;
  logic          last_was_frame, last_was_frame_nxt;
  logic          frame_start;
  logic          con_take;
  logic          tick;

  refresh_ticker #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_ticker (
    .clk48(clk48),
    .rst  (rst),
    .tick (tick)
  );

  // Keep the handshake quiet while reset is held, since IDLE is the reset state.
  assign con_ready = con_take & ~rst;

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      src            <= SRC_ANN;
      tx_data        <= 8'h00;
      byte_cnt       <= '0;
      frame_active   <= 1'b0;
      frame_pend     <= 1'b0;
      frame_overrun  <= 1'b0;
      last_was_frame <= 1'b0;
    end else begin
      state          <= state_nxt;
      src            <= src_nxt;
      tx_data        <= tx_data_nxt;
      byte_cnt       <= byte_cnt_nxt;
      frame_active   <= frame_active_nxt;
      frame_pend     <= frame_pend_nxt;
      frame_overrun  <= frame_overrun_nxt;
      last_was_frame <= last_was_frame_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    src_nxt            = src;
    tx_data_nxt        = tx_data;
    byte_cnt_nxt       = byte_cnt;
    frame_active_nxt   = frame_active;
    last_was_frame_nxt = last_was_frame;
    frame_start        = 1'b0;
    con_take           = 1'b0;
    ann_inc            = 1'b0;
    tx_valid           = 1'b0;

    case (state)
      ST_IDLE: begin
        // A pending frame wins unless a frame just went out; then the console gets one byte.
        if (frame_pend && !last_was_frame) begin
          frame_start = 1'b1;
        end else if (con_valid) begin
          con_take    = 1'b1;
          tx_data_nxt = con_data;
          src_nxt     = SRC_CON;
          state_nxt   = ST_SEND;
        end else if (frame_pend) begin
          frame_start = 1'b1;
        end
        if (frame_start) begin
          byte_cnt_nxt     = '0;
          frame_active_nxt = 1'b1;
          state_nxt        = ST_ANN_REQ;
        end
      end
      ST_ANN_REQ: begin
        ann_inc   = 1'b1;
        state_nxt = ST_ANN_CAP;
      end
      ST_ANN_CAP: begin
        tx_data_nxt = ann_q;
        src_nxt     = SRC_ANN;
        state_nxt   = ST_SEND;
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (src == SRC_ANN) begin
            if (byte_cnt == BLAST) begin
              byte_cnt_nxt       = '0;
              frame_active_nxt   = 1'b0;
              last_was_frame_nxt = 1'b1;
              state_nxt          = ST_IDLE;
            end else begin
              byte_cnt_nxt = byte_cnt + BW'(1);
              state_nxt    = ST_ANN_REQ;
            end
          end else begin
            last_was_frame_nxt = 1'b0;
            state_nxt          = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A tick coinciding with frame start re-arms the next frame rather than overrunning.
    frame_pend_nxt    = tick | (frame_pend & ~frame_start);
    frame_overrun_nxt = frame_overrun | (tick & frame_pend & ~frame_start);
  end

endmodule

// File: tb/tb_status_tx_scheduler.sv
// Directed bench: dut_a (4-byte frames) for sequencing/arbitration, dut_b (50-byte frames) for overrun.
module tb_status_tx_scheduler;

  logic clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  logic       rst_a, ann_inc_a, con_valid_a, con_ready_a, tx_valid_a, tx_ready_a;
  logic       frame_active_a, frame_overrun_a;
  logic [7:0] ann_q_a, con_data_a, tx_data_a;
  logic       rst_b, ann_inc_b, con_valid_b, con_ready_b, tx_valid_b, tx_ready_b;
  logic       frame_active_b, frame_overrun_b;
  logic [7:0] ann_q_b, con_data_b, tx_data_b;

  status_tx_scheduler #(.FRAME_LEN(4), .REFRESH_CYCLES(20)) dut_a (
    .clk48(clk48), .rst(rst_a), .ann_inc(ann_inc_a), .ann_q(ann_q_a),
    .con_valid(con_valid_a), .con_data(con_data_a), .con_ready(con_ready_a),
    .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
    .frame_active(frame_active_a), .frame_overrun(frame_overrun_a)
  );

  status_tx_scheduler #(.FRAME_LEN(50), .REFRESH_CYCLES(20)) dut_b (
    .clk48(clk48), .rst(rst_b), .ann_inc(ann_inc_b), .ann_q(ann_q_b),
    .con_valid(con_valid_b), .con_data(con_data_b), .con_ready(con_ready_b),
    .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
    .frame_active(frame_active_b), .frame_overrun(frame_overrun_b)
  );

  // Annunciator models: byte k of the stream is base+k, restarting at reset.
  logic [7:0] idx_a, idx_b;
  always @(posedge clk48 or posedge rst_a)
    if (rst_a) begin idx_a <= 8'd0; ann_q_a <= 8'd0; end
    else if (ann_inc_a) begin ann_q_a <= 8'hA0 + idx_a; idx_a <= idx_a + 8'd1; end
  always @(posedge clk48 or posedge rst_b)
    if (rst_b) begin idx_b <= 8'd0; ann_q_b <= 8'd0; end
    else if (ann_inc_b) begin ann_q_b <= idx_b; idx_b <= idx_b + 8'd1; end

  int n_inc_a = 0, n_fa_a = 0, n_conviol_a = 0, n_incvalid_a = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  always @(posedge clk48) begin
    if (!rst_a) begin
      if (ann_inc_a) n_inc_a++;
      if (ann_inc_a && tx_valid_a) n_incvalid_a++;
      if (frame_active_a) n_fa_a++;
      if (frame_active_a && con_ready_a) n_conviol_a++;
      if (tx_valid_a && tx_ready_a) q_a.push_back(tx_data_a);
    end
    if (!rst_b && tx_valid_b && tx_ready_b) q_b.push_back(tx_data_b);
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fa_a(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (frame_active_a !== lvl && n < budget) begin @(negedge clk48); n++; end
    check(tag, 32'(frame_active_a), 32'(lvl));
  endtask

  task automatic wait_fa_b(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (frame_active_b !== lvl && n < budget) begin @(negedge clk48); n++; end
    check(tag, 32'(frame_active_b), 32'(lvl));
  endtask

  initial begin
    int base, inc0, fa0, qs, viol0, n;
    rst_a = 1'b1; rst_b = 1'b1;
    con_valid_a = 1'b1; con_data_a = 8'h41; tx_ready_a = 1'b1;
    con_valid_b = 1'b0; con_data_b = 8'h00; tx_ready_b = 1'b1;
    repeat (3) @(negedge clk48);

    // Reset values, with a console request pending that must not be acknowledged
    check("rst_ann_inc", 32'(ann_inc_a), 0);
    check("rst_con_ready", 32'(con_ready_a), 0);
    check("rst_tx_valid", 32'(tx_valid_a), 0);
    check("rst_tx_data", 32'(tx_data_a), 0);
    check("rst_frame_active", 32'(frame_active_a), 0);
    check("rst_frame_overrun", 32'(frame_overrun_a), 0);
    check("rst_b_tx_valid", 32'(tx_valid_b), 0);
    check("rst_b_frame_active", 32'(frame_active_b), 0);
    con_valid_a = 1'b0;
    rst_a = 1'b0;

    // Frame 1: four bytes back to back, 12 cycles of frame_active
    base = q_a.size(); inc0 = n_inc_a; fa0 = n_fa_a;
    wait_fa_a(1'b1, 60, "f1_start");
    wait_fa_a(1'b0, 60, "f1_end");
    check("f1_ann_inc_pulses", 32'(n_inc_a - inc0), 4);
    check("f1_active_cycles", 32'(n_fa_a - fa0), 12);
    check("f1_transfers", 32'(q_a.size() - base), 4);
    for (int i = 0; i < 4; i++) check("f1_byte", 32'(q_a[base + i]), 32'(8'hA0 + i));

    // Frame 2: UART stalls on the first byte
    tx_ready_a = 1'b0;
    base = q_a.size();
    wait_fa_a(1'b1, 40, "f2_start");
    n = 0;
    while (tx_valid_a !== 1'b1 && n < 10) begin @(negedge clk48); n++; end
    check("f2_offer", 32'(tx_valid_a), 1);
    check("f2_offer_data", 32'(tx_data_a), 32'h A4);
    inc0 = n_inc_a; qs = q_a.size();
    repeat (5) begin
      @(negedge clk48);
      check("stall_tx_valid", 32'(tx_valid_a), 1);
      check("stall_tx_data", 32'(tx_data_a), 32'hA4);
    end
    check("stall_no_ann_inc", 32'(n_inc_a - inc0), 0);
    check("stall_no_transfer", 32'(q_a.size()), 32'(qs));
    tx_ready_a = 1'b1;
    wait_fa_a(1'b0, 60, "f2_end");
    check("f2_transfers", 32'(q_a.size() - base), 4);
    for (int i = 0; i < 4; i++) check("f2_byte", 32'(q_a[base + i]), 32'(8'hA4 + i));

    // Frame 3: console requests throughout; exactly one console byte before frame 4
    wait_fa_a(1'b1, 40, "f3_start");
    base = q_a.size(); viol0 = n_conviol_a;
    con_data_a = 8'h41; con_valid_a = 1'b1;
    wait_fa_a(1'b0, 60, "f3_end");
    check("f3_con_ready_in_frame", 32'(n_conviol_a - viol0), 0);
    n = 0;
    while (con_ready_a !== 1'b1 && n < 10) begin @(negedge clk48); n++; end
    check("f3_con_ready_after", 32'(con_ready_a), 1);
    @(posedge clk48);
    @(negedge clk48);
    con_valid_a = 1'b0;
    wait_fa_a(1'b1, 40, "f4_start");
    check("f3_plus_con_transfers", 32'(q_a.size() - base), 5);
    for (int i = 0; i < 4; i++) check("f3_byte", 32'(q_a[base + i]), 32'(8'hA8 + i));
    check("con_byte", 32'(q_a[base + 4]), 32'h41);

    // After frame 4: frame pending and console requesting together -> console first
    wait_fa_a(1'b0, 60, "f4_end");
    base = q_a.size();
    n = 0;
    while (dut_a.u_ticker.tick !== 1'b1 && n < 40) begin @(negedge clk48); n++; end
    @(negedge clk48);
    con_data_a = 8'h5A; con_valid_a = 1'b1;
    #1;
    check("tie_con_ready", 32'(con_ready_a), 1);
    @(posedge clk48);
    @(negedge clk48);
    con_valid_a = 1'b0;
    wait_fa_a(1'b1, 20, "f5_start");
    check("tie_transfers_before_frame", 32'(q_a.size() - base), 1);
    check("tie_con_byte", 32'(q_a[base]), 32'h5A);
    check("no_overrun_a", 32'(frame_overrun_a), 0);

    // Reset mid-frame while fetching byte 2
    base = q_a.size();
    n = 0;
    while (q_a.size() - base < 2 && n < 30) begin @(negedge clk48); n++; end
    check("f5_two_bytes", 32'(q_a.size() - base), 2);
    #2 rst_a = 1'b1;
    #1;
    check("mid_rst_ann_inc", 32'(ann_inc_a), 0);
    check("mid_rst_tx_valid", 32'(tx_valid_a), 0);
    check("mid_rst_tx_data", 32'(tx_data_a), 0);
    check("mid_rst_frame_active", 32'(frame_active_a), 0);
    @(negedge clk48);
    rst_a = 1'b0;
    base = q_a.size();
    wait_fa_a(1'b1, 40, "f6_start");
    wait_fa_a(1'b0, 60, "f6_end");
    check("f6_transfers", 32'(q_a.size() - base), 4);
    for (int i = 0; i < 4; i++) check("f6_byte", 32'(q_a[base + i]), 32'(8'hA0 + i));
    check("ann_inc_while_tx_valid", 32'(n_incvalid_a), 0);

    // dut_b: 50-byte frames outlast the 20-cycle refresh -> sticky overrun
    rst_b = 1'b0;
    wait_fa_b(1'b1, 40, "b_f1_start");
    check("b_overrun_early", 32'(frame_overrun_b), 0);
    repeat (40) @(negedge clk48);
    check("b_overrun_40", 32'(frame_overrun_b), 1);
    wait_fa_b(1'b0, 200, "b_f1_end");
    check("b_f1_transfers", 32'(q_b.size()), 50);
    check("b_f1_first", 32'(q_b[0]), 0);
    check("b_f1_last", 32'(q_b[49]), 49);
    wait_fa_b(1'b1, 10, "b_f2_start");
    check("b_overrun_sticky", 32'(frame_overrun_b), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
